// File: rtl/byteswap_rd_master.sv
// AXI4 burst read master feeding the byteswap word-swap stage as an AXI4-Stream; R->stream is zero latency, or 1 cycle with BYTESWAP_RD_SKID_EN.
// Backpressure: tready stalls RREADY (combinationally, or through a 2-entry skid buffer with BYTESWAP_RD_SKID_EN); ARs stop at C_MAX_OUTSTANDING.
module byteswap_rd_master #(
    parameter int C_M_AXI_GMEM_ADDR_WIDTH = 64,
    parameter int C_M_AXI_GMEM_DATA_WIDTH = 32,
    parameter int C_XFER_SIZE_WIDTH       = 32,
    parameter int C_BURST_LEN             = 16,
    parameter int C_MAX_OUTSTANDING       = 4
) (
    input  logic                               ap_clk,
    input  logic                               areset,
    input  logic                               ctrl_start,
    input  logic [C_M_AXI_GMEM_ADDR_WIDTH-1:0] ctrl_addr_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0]       ctrl_xfer_size_in_bytes,
    output logic                               ctrl_done,
    output logic                               rd_error,
    output logic                               m_axi_gmem_ARVALID,
    input  logic                               m_axi_gmem_ARREADY,
    output logic [C_M_AXI_GMEM_ADDR_WIDTH-1:0] m_axi_gmem_ARADDR,
    output logic [7:0]                         m_axi_gmem_ARLEN,
    input  logic                               m_axi_gmem_RVALID,
    output logic                               m_axi_gmem_RREADY,
    input  logic [C_M_AXI_GMEM_DATA_WIDTH-1:0] m_axi_gmem_RDATA,
    input  logic                               m_axi_gmem_RLAST,
    input  logic [1:0]                         m_axi_gmem_RRESP,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic [C_M_AXI_GMEM_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                               m_axis_tlast
);

    localparam int AW    = C_M_AXI_GMEM_ADDR_WIDTH;
    localparam int DW    = C_M_AXI_GMEM_DATA_WIDTH;
    localparam int XW    = C_XFER_SIZE_WIDTH;
    localparam int BYTES = DW / 8;
    localparam int ALIGN = $clog2(BYTES);

    localparam logic [AW-1:0] BURST_STEP = AW'(C_BURST_LEN * BYTES);
    localparam logic [AW-1:0] ADDR_MASK  = ~AW'(BYTES - 1);
    localparam logic [XW-1:0] BL_BEATS   = XW'(C_BURST_LEN);
    localparam logic [3:0]    MAX_OUT    = 4'(C_MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_q, state_d;

    logic [AW-1:0] araddr_q, araddr_d;
    logic [7:0]    arlen_q, arlen_d;
    logic          arvalid_q, arvalid_d;
    logic [XW-1:0] ar_left_q, ar_left_d;
    logic [XW-1:0] beats_left_q, beats_left_d;
    logic [3:0]    out_q, out_d, out_next;
    logic          err_q, err_d;

    logic          run, start_ok, ar_hs, r_hs, s_hs, r_last_hs, last_beat;
    logic [XW-1:0] total_beats, first_burst, next_burst;

    assign run         = (state_q == RUN);
    assign start_ok    = ctrl_start && (state_q == IDLE);
    assign total_beats = XW'(({1'b0, ctrl_xfer_size_in_bytes} + (XW+1)'(BYTES - 1)) >> ALIGN);
    assign first_burst = (total_beats >= BL_BEATS) ? BL_BEATS : total_beats;
    assign next_burst  = (ar_left_q >= BL_BEATS) ? BL_BEATS : ar_left_q;
    assign ar_hs       = arvalid_q && m_axi_gmem_ARREADY;
    assign r_last_hs   = r_hs && m_axi_gmem_RLAST;
    assign last_beat   = s_hs && (beats_left_q == XW'(1));
    assign out_next    = out_q + {3'b000, ar_hs} - {3'b000, r_last_hs};

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ctrl_start) state_d = (total_beats == '0) ? DONE : RUN;
            RUN:     if (last_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ctrl_done = (state_q == DONE);
    end

    always_comb begin
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arvalid_d    = arvalid_q;
        ar_left_d    = ar_left_q;
        beats_left_d = beats_left_q;
        out_d        = out_q;
        err_d        = err_q;
        if (start_ok) begin
            // The first burst is queued here so ARVALID rises the cycle after start.
            araddr_d     = ctrl_addr_offset & ADDR_MASK;
            arvalid_d    = (total_beats != '0);
            arlen_d      = (total_beats != '0) ? 8'(first_burst - XW'(1)) : 8'd0;
            ar_left_d    = total_beats - first_burst;
            beats_left_d = total_beats;
            out_d        = 4'd0;
            err_d        = 1'b0;
        end else if (run) begin
            out_d = out_next;
            if (ar_hs) begin
                araddr_d  = araddr_q + BURST_STEP;
                arvalid_d = 1'b0;
            end
            if ((ar_hs || !arvalid_q) && (ar_left_q != '0) && (out_next < MAX_OUT)) begin
                arvalid_d = 1'b1;
                arlen_d   = 8'(next_burst - XW'(1));
                ar_left_d = ar_left_q - next_burst;
            end
            if (s_hs) beats_left_d = beats_left_q - XW'(1);
            if (r_hs && (m_axi_gmem_RRESP != 2'b00)) err_d = 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            araddr_q     <= '0;
            arlen_q      <= '0;
            arvalid_q    <= 1'b0;
            ar_left_q    <= '0;
            beats_left_q <= '0;
            out_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arvalid_q    <= arvalid_d;
            ar_left_q    <= ar_left_d;
            beats_left_q <= beats_left_d;
            out_q        <= out_d;
            err_q        <= err_d;
        end
    end

    assign m_axi_gmem_ARVALID = arvalid_q;
    assign m_axi_gmem_ARADDR  = araddr_q;
    assign m_axi_gmem_ARLEN   = arlen_q;
    assign rd_error           = err_q;
    // TLAST comes from the beat counter, which only moves on a stream handshake.
    assign m_axis_tlast       = (beats_left_q == XW'(1));

`ifdef BYTESWAP_RD_SKID_EN
    logic [1:0]    skid_cnt_q, skid_cnt_d;
    logic [DW-1:0] skid_ent0_q, skid_ent0_d, skid_ent1_q, skid_ent1_d;
    logic          rready_q, rready_d;
    logic          push, pop;

    assign push = m_axi_gmem_RVALID && rready_q;
    assign pop  = (skid_cnt_q != 2'd0) && m_axis_tready;

    always_comb begin
        skid_cnt_d  = skid_cnt_q;
        skid_ent0_d = skid_ent0_q;
        skid_ent1_d = skid_ent1_q;
        case ({push, pop})
            2'b10: begin
                if (skid_cnt_q == 2'd0) skid_ent0_d = m_axi_gmem_RDATA;
                else                    skid_ent1_d = m_axi_gmem_RDATA;
                skid_cnt_d = skid_cnt_q + 2'd1;
            end
            2'b01: begin
                skid_ent0_d = skid_ent1_q;
                skid_cnt_d  = skid_cnt_q - 2'd1;
            end
            2'b11: begin
                if (skid_cnt_q == 2'd1) begin
                    skid_ent0_d = m_axi_gmem_RDATA;
                end else begin
                    skid_ent0_d = skid_ent1_q;
                    skid_ent1_d = m_axi_gmem_RDATA;
                end
            end
            default: ;
        endcase
        rready_d = (state_d == RUN) && (skid_cnt_d < 2'd2);
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            skid_cnt_q  <= 2'd0;
            skid_ent0_q <= '0;
            skid_ent1_q <= '0;
            rready_q    <= 1'b0;
        end else begin
            skid_cnt_q  <= skid_cnt_d;
            skid_ent0_q <= skid_ent0_d;
            skid_ent1_q <= skid_ent1_d;
            rready_q    <= rready_d;
        end
    end

    assign r_hs              = push;
    assign s_hs              = pop;
    assign m_axi_gmem_RREADY = rready_q;
    assign m_axis_tvalid     = (skid_cnt_q != 2'd0);
    assign m_axis_tdata      = skid_ent0_q;
`else
    assign r_hs              = run && m_axi_gmem_RVALID && m_axis_tready;
    assign s_hs              = r_hs;
    assign m_axi_gmem_RREADY = run && m_axis_tready;
    assign m_axis_tvalid     = run && m_axi_gmem_RVALID;
    assign m_axis_tdata      = run ? m_axi_gmem_RDATA : '0;
`endif

endmodule

// File: tb/tb_byteswap_rd_master.sv
// Bench for byteswap_rd_master: randomised AXI slave and stream sink, checked against a burst/word reference model.
module tb_byteswap_rd_master;

    logic        ap_clk = 1'b0;
    logic        areset, ctrl_start;
    logic [63:0] ctrl_addr_offset;
    logic [31:0] ctrl_xfer_size_in_bytes;
    logic        ctrl_done, rd_error;
    logic        m_axi_gmem_ARVALID, m_axi_gmem_ARREADY;
    logic [63:0] m_axi_gmem_ARADDR;
    logic [7:0]  m_axi_gmem_ARLEN;
    logic        m_axi_gmem_RVALID, m_axi_gmem_RREADY, m_axi_gmem_RLAST;
    logic [31:0] m_axi_gmem_RDATA;
    logic [1:0]  m_axi_gmem_RRESP;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [31:0] m_axis_tdata;

    always #5 ap_clk = ~ap_clk;

    byteswap_rd_master dut (
        .ap_clk(ap_clk), .areset(areset), .ctrl_start(ctrl_start),
        .ctrl_addr_offset(ctrl_addr_offset), .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes),
        .ctrl_done(ctrl_done), .rd_error(rd_error),
        .m_axi_gmem_ARVALID(m_axi_gmem_ARVALID), .m_axi_gmem_ARREADY(m_axi_gmem_ARREADY),
        .m_axi_gmem_ARADDR(m_axi_gmem_ARADDR), .m_axi_gmem_ARLEN(m_axi_gmem_ARLEN),
        .m_axi_gmem_RVALID(m_axi_gmem_RVALID), .m_axi_gmem_RREADY(m_axi_gmem_RREADY),
        .m_axi_gmem_RDATA(m_axi_gmem_RDATA), .m_axi_gmem_RLAST(m_axi_gmem_RLAST),
        .m_axi_gmem_RRESP(m_axi_gmem_RRESP),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // Slave model state
    logic [63:0] bq_addr[$];
    int          bq_len[$];
    int          beat_idx, r_beats_total, err_beat;
    bit          arready_rand, rvalid_on, rvalid_rand, tready_rand, rv_hold;

    // Observations
    logic [63:0] ar_addr_q[$];
    int          ar_len_q[$];
    int          ar_cyc_q[$];
    logic [31:0] s_dat_q[$];
    bit          s_last_q[$];
    int          s_cyc_q[$];
    int          cycle, start_cyc, done_cnt, done_cyc, first_rlast_cyc, first_arv_cyc;
    bit          err_at_done;

    bit          st_prev, st_last, ar_prev;
    logic [31:0] st_dat;
    logic [63:0] ar_a;
    logic [7:0]  ar_l;

    bit          start_req, rst_req;
    logic [63:0] off_req;
    logic [31:0] size_req;

    task automatic tick();
        @(negedge ap_clk);
        cycle++;
        areset                  = rst_req;
        ctrl_start              = start_req;
        ctrl_addr_offset        = off_req;
        ctrl_xfer_size_in_bytes = size_req;
        start_req = 1'b0;
        rst_req   = 1'b0;
        if (areset) begin
            bq_addr.delete();
            bq_len.delete();
            beat_idx = 0;
            rv_hold  = 1'b0;
        end
        m_axi_gmem_ARREADY = arready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (bq_addr.size() != 0) begin
            m_axi_gmem_RVALID = rv_hold || (rvalid_on && (!rvalid_rand || $urandom_range(0, 3) != 0));
            m_axi_gmem_RDATA  = mem_word(bq_addr[0] + 64'(beat_idx * 4));
            m_axi_gmem_RLAST  = (beat_idx == bq_len[0]);
            m_axi_gmem_RRESP  = (r_beats_total == err_beat) ? 2'd2 : 2'd0;
        end else begin
            m_axi_gmem_RVALID = 1'b0;
            m_axi_gmem_RDATA  = '0;
            m_axi_gmem_RLAST  = 1'b0;
            m_axi_gmem_RRESP  = 2'd0;
        end
        m_axis_tready = tready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        if (st_prev) begin
            check_eq("tvalid_hold", m_axis_tvalid, 1);
            check_eq("tdata_hold", m_axis_tdata, st_dat);
            check_eq("tlast_hold", m_axis_tlast, st_last);
        end
        if (ar_prev) begin
            check_eq("arvalid_hold", m_axi_gmem_ARVALID, 1);
            check_eq("araddr_hold", m_axi_gmem_ARADDR, ar_a);
            check_eq("arlen_hold", m_axi_gmem_ARLEN, ar_l);
        end
        st_prev = m_axis_tvalid && !m_axis_tready && !areset;
        st_dat  = m_axis_tdata;
        st_last = m_axis_tlast;
        ar_prev = m_axi_gmem_ARVALID && !m_axi_gmem_ARREADY && !areset;
        ar_a    = m_axi_gmem_ARADDR;
        ar_l    = m_axi_gmem_ARLEN;
        if (m_axi_gmem_ARVALID && first_arv_cyc < 0) first_arv_cyc = cycle;
        if (ctrl_done) begin
            done_cnt++;
            done_cyc    = cycle;
            err_at_done = rd_error;
        end
        if (!areset) begin
            if (m_axi_gmem_RVALID && m_axi_gmem_RREADY) begin
                if (m_axi_gmem_RLAST && first_rlast_cyc < 0) first_rlast_cyc = cycle;
                r_beats_total++;
                rv_hold = 1'b0;
                if (m_axi_gmem_RLAST) begin
                    void'(bq_addr.pop_front());
                    void'(bq_len.pop_front());
                    beat_idx = 0;
                end else begin
                    beat_idx++;
                end
            end else if (m_axi_gmem_RVALID) begin
                rv_hold = 1'b1;
            end
            if (m_axi_gmem_ARVALID && m_axi_gmem_ARREADY) begin
                ar_addr_q.push_back(m_axi_gmem_ARADDR);
                ar_len_q.push_back(int'(m_axi_gmem_ARLEN));
                ar_cyc_q.push_back(cycle);
                bq_addr.push_back(m_axi_gmem_ARADDR);
                bq_len.push_back(int'(m_axi_gmem_ARLEN));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                s_dat_q.push_back(m_axis_tdata);
                s_last_q.push_back(m_axis_tlast);
                s_cyc_q.push_back(cycle);
            end
        end
    endtask

    task automatic start_xfer(input logic [63:0] off, input int size, input int errb);
        ar_addr_q.delete(); ar_len_q.delete(); ar_cyc_q.delete();
        s_dat_q.delete(); s_last_q.delete(); s_cyc_q.delete();
        done_cnt = 0; done_cyc = -1; first_rlast_cyc = -1; first_arv_cyc = -1;
        err_beat = errb; r_beats_total = 0;
        off_req = off; size_req = 32'(size); start_req = 1'b1;
        tick();
        start_cyc = cycle;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check_eq("done_count", done_cnt, 1);
    endtask

    // Reference: bursts of up to 16 beats every 64 bytes, words read in address order.
    task automatic verify_xfer(input logic [63:0] off, input int size);
        logic [63:0] base = off & ~64'h3;
        int beats = (size + 3) / 4;
        int nb = (beats + 15) / 16;
        int rem = beats;
        check_eq("ar_count", ar_addr_q.size(), nb);
        for (int k = 0; k < nb && k < ar_addr_q.size(); k++) begin
            check_eq("ar_addr", ar_addr_q[k], base + 64'(k * 64));
            check_eq("ar_len", ar_len_q[k], ((rem > 16) ? 16 : rem) - 1);
            rem -= 16;
        end
        check_eq("beat_count", s_dat_q.size(), beats);
        for (int i = 0; i < beats && i < s_dat_q.size(); i++) begin
            check_eq("tdata", s_dat_q[i], mem_word(base + 64'(i * 4)));
            check_eq("tlast", s_last_q[i], i == beats - 1);
        end
        if (beats > 0) begin
            if (s_cyc_q.size() > 0) check_eq("done_after_last", done_cyc, s_cyc_q[s_cyc_q.size()-1] + 1);
            check_eq("first_arvalid", first_arv_cyc, start_cyc + 1);
        end else begin
            check_eq("zero_done", done_cyc, start_cyc + 1);
            check_eq("zero_no_arvalid", first_arv_cyc, -1);
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_done", ctrl_done, 0);
        check_eq("rst_err", rd_error, 0);
        check_eq("rst_arvalid", m_axi_gmem_ARVALID, 0);
        check_eq("rst_araddr", m_axi_gmem_ARADDR, 0);
        check_eq("rst_arlen", m_axi_gmem_ARLEN, 0);
        check_eq("rst_rready", m_axi_gmem_RREADY, 0);
        check_eq("rst_tvalid", m_axis_tvalid, 0);
        check_eq("rst_tdata", m_axis_tdata, 0);
        check_eq("rst_tlast", m_axis_tlast, 0);
    endtask

    initial begin
        areset = 1'b1; ctrl_start = 1'b0; ctrl_addr_offset = '0; ctrl_xfer_size_in_bytes = '0;
        m_axi_gmem_ARREADY = 1'b0; m_axi_gmem_RVALID = 1'b0; m_axi_gmem_RDATA = '0;
        m_axi_gmem_RLAST = 1'b0; m_axi_gmem_RRESP = 2'd0; m_axis_tready = 1'b0;
        cycle = 0; beat_idx = 0; r_beats_total = 0; err_beat = -1;
        arready_rand = 0; rvalid_on = 1; rvalid_rand = 0; tready_rand = 0; rv_hold = 0;
        st_prev = 0; ar_prev = 0; start_req = 0; off_req = '0; size_req = '0;
        done_cnt = 0; done_cyc = -1; first_rlast_cyc = -1; first_arv_cyc = -1; start_cyc = 0;

        rst_req = 1'b1; tick();
        rst_req = 1'b1; tick();
        check_reset_outputs();
        tick();

        // Single full burst
        start_xfer(64'h1000, 'h40, -1);
        wait_done(200);
        verify_xfer(64'h1000, 'h40);

        // Partial last burst; a second start while running must be ignored
        start_xfer(64'h0, 'h8A, -1);
        repeat (5) tick();
        off_req = 64'h3000; size_req = 32'd4; start_req = 1'b1;
        tick();
        wait_done(300);
        verify_xfer(64'h0, 'h8A);

        // Outstanding limit with R withheld
        rvalid_on = 0;
        start_xfer(64'h0, 'h400, -1);
        repeat (40) tick();
        check_eq("ar_at_limit", ar_addr_q.size(), 4);
        check_eq("arvalid_at_limit", m_axi_gmem_ARVALID, 0);
        rvalid_on = 1;
        wait_done(2000);
        check_eq("ar5_cycle", (ar_cyc_q.size() > 4) ? ar_cyc_q[4] : -1, first_rlast_cyc + 1);
        verify_xfer(64'h0, 'h400);

        // 1000 beats with random backpressure on every channel
        arready_rand = 1; rvalid_rand = 1; tready_rand = 1;
        start_xfer(64'h2000, 4000, -1);
        wait_done(20000);
        verify_xfer(64'h2000, 4000);
        check_eq("clean_err", err_at_done, 0);

        // Error response on the 5th beat, cleared by the next start
        start_xfer(64'h0, 'h40, 4);
        wait_done(2000);
        verify_xfer(64'h0, 'h40);
        check_eq("err_at_done", err_at_done, 1);
        check_eq("err_sticky_idle", rd_error, 1);
        start_xfer(64'h40, 'h20, -1);
        tick();
        check_eq("err_cleared", rd_error, 0);
        wait_done(2000);
        verify_xfer(64'h40, 'h20);
        arready_rand = 0; rvalid_rand = 0; tready_rand = 0;

        // Zero-size transfer
        start_xfer(64'h500, 0, -1);
        wait_done(20);
        verify_xfer(64'h500, 0);

        // Reset mid-burst, then recover
        start_xfer(64'h0, 'h400, -1);
        repeat (20) tick();
        check_eq("midrst_active", m_axis_tvalid || m_axi_gmem_RREADY, 1);
        rst_req = 1'b1; tick();
        tick();
        check_reset_outputs();
        start_xfer(64'h1000, 'h40, -1);
        wait_done(200);
        verify_xfer(64'h1000, 'h40);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/byteswap_rd_master.md
# byteswap_rd_master

AXI4 read master that fetches the byteswap source buffer from global memory and delivers it as an AXI4-Stream of words to the swap datapath inside the byteswap kernel. It sits directly upstream of the word-swap stage. Its launch and completion signals come from the kernel controller (ap_start/gmem_ptr/xfer_size). It splits the transfer into fixed-length bursts, bounds outstanding reads, and marks the final word with TLAST.

## Interface
- C_M_AXI_GMEM_ADDR_WIDTH, 64, AXI address width
- C_M_AXI_GMEM_DATA_WIDTH, 32, AXI/stream data width; power of 2, ≥8
- C_XFER_SIZE_WIDTH, 32, width of the byte-count input
- C_BURST_LEN, 16, beats per full burst; power of 2, 2..256
- C_MAX_OUTSTANDING, 4, maximum issued-but-incomplete bursts; 1..15

Ports:
- ap_clk  in  1  sole clock
- areset  in  1  reset; synchronous, active-high
- ctrl_start  in  1  single-cycle launch pulse
- ctrl_addr_offset  in  C_M_AXI_GMEM_ADDR_WIDTH  byte start address; sampled on ctrl_start
- ctrl_xfer_size_in_bytes  in  C_XFER_SIZE_WIDTH  byte count; sampled on ctrl_start
- ctrl_done  out  1  single-cycle completion pulse
- rd_error  out  1  sticky flag: an RRESP≠OKAY was seen during the current transfer
- m_axi_gmem_ARVALID / ARREADY  out/in  1  read-address handshake
- m_axi_gmem_ARADDR  out  C_M_AXI_GMEM_ADDR_WIDTH  burst address
- m_axi_gmem_ARLEN  out  8  beats−1
- m_axi_gmem_RVALID / RREADY  in/out  1  read-data handshake
- m_axi_gmem_RDATA  in  C_M_AXI_GMEM_DATA_WIDTH  read data
- m_axi_gmem_RLAST  in  1  last beat of a burst
- m_axi_gmem_RRESP  in  2  read response
- m_axis_tvalid / tready  out/in  1  stream handshake to the swap stage
- m_axis_tdata  out  C_M_AXI_GMEM_DATA_WIDTH  word
- m_axis_tlast  out  1  final word of the transfer

## Operation
- BYTES = C_M_AXI_GMEM_DATA_WIDTH/8.
- total_beats = ceil(size/BYTES). The final word of a non-multiple size carries the full memory word; the swap stage ignores trailing bytes.
- Address alignment:
  - ctrl_addr_offset low log2(BYTES) bits are forced to 0.
  - The offset must be aligned to C_BURST_LEN·BYTES so no burst crosses a 4 KB boundary. The block does not check this.
- States and transitions:
  - IDLE → RUN on ctrl_start.
  - RUN → DONE when the last stream beat is accepted.
  - DONE → IDLE after one cycle. DONE is the cycle ctrl_done=1.
- ctrl_start is ignored outside IDLE.
- Zero-size transfer: IDLE → DONE directly. ctrl_done pulses the cycle after start; no AR is issued and no stream beat is produced.
- AR issue:
  - Bursts are C_BURST_LEN beats, except the last, which is the remaining beats.
  - ARADDR advances by C_BURST_LEN·BYTES per accepted AR (full-width add, wrap ignored).
  - ARLEN = beats−1.
- Outstanding counter:
  - +1 on AR handshake, −1 on an R handshake with RLAST. A simultaneous +1/−1 leaves it unchanged.
  - ARVALID is not asserted while the counter equals C_MAX_OUTSTANDING.
- Beat counter decrements on each stream handshake. tlast = 1 when it equals 1.
- rd_error:
  - Cleared on an accepted ctrl_start.
  - Set on any R handshake with RRESP≠0.
  - Data is still forwarded after an error.
- RLAST is used only for the outstanding count; stream TLAST is derived from the beat counter.
- Reset mid-transfer: all state returns to IDLE and counters clear. The interconnect must be reset alongside, because in-flight R beats are not drained.

## Timing
- Reset values: ctrl_done=0, rd_error=0, ARVALID=0, ARADDR=0, ARLEN=0, RREADY=0, tvalid=0, tdata=0, tlast=0.
- First ARVALID is asserted the cycle after ctrl_start.
- ARVALID, ARADDR and ARLEN are held stable until ARREADY; ARVALID never drops without a handshake.
- Back-to-back ARs are allowed: the next ARVALID is in the cycle after a handshake when the outstanding limit permits.
- Stream handshake rules: tvalid is not withdrawn, and tdata/tlast do not change, while tvalid=1 and tready=0.
- ctrl_done is asserted exactly one cycle after the final stream handshake.
- Default (macro absent):
  - tvalid = RVALID in RUN.
  - RREADY = tready in RUN.
  - tdata = RDATA.
  - Zero latency R→stream.

## Configuration
- BYTESWAP_RD_SKID_EN defined:
  - A 2-entry skid buffer sits between R and the stream.
  - RREADY is a register, equal to "fewer than 2 entries, or 1 entry and it is popping".
  - tvalid, tdata and tlast are registered.
  - R→stream latency is 1 cycle.
  - There is no combinational path from tready to RREADY.
  - Full throughput is sustained at 1 beat/cycle.
  - ctrl_done is still asserted one cycle after the final stream handshake.
- Undefined: pass-through behaviour as in Timing.

## Test plan
- Size 0x40, offset 0x1000, C_BURST_LEN=16, BYTES=4, slave always ready:
  - one AR with ARADDR=0x1000 and ARLEN=15;
  - 16 stream beats with tlast on the 16th;
  - ctrl_done one cycle later.
- Size 0x8A (35 beats):
  - ARs at 0x0/0x40/0x80 with ARLEN 15/15/2;
  - tlast on beat 35;
  - data order matches memory.
- Size 0x400 (16 bursts), ARREADY=1, RVALID withheld:
  - exactly 4 ARs are issued, then ARVALID stays 0;
  - a 5th AR is issued in the cycle after the first RLAST handshake.
- Random tready/RVALID backpressure over a 1000-beat transfer:
  - no lost or duplicated words;
  - tdata/tlast stable while stalled, in both macro settings.
- RRESP=2 on beat 5: rd_error rises and stays 1 through ctrl_done; the next ctrl_start clears it.
- Fault and corner cases:
  - areset asserted mid-burst: all outputs return to reset values the next cycle.
  - Size 0: ctrl_done pulses the cycle after start, with no ARVALID.
  - ctrl_start while in RUN: ignored.
